// File: rtl/cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmd_arbiter : shares the cmd_cfg command port among remote, aux and the     |
// |               link-loss failsafe, and routes responses back to the owner.   |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module cmd_arbiter #(
    parameter int         WDOG_W  = 9,
    parameter logic [7:0] EMER_OP = 8'h07
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rmt_cmd_rdy,
    input  logic [7:0]  rmt_cmd,
    input  logic [15:0] rmt_data,
    output logic        rmt_clr_cmd_rdy,
    output logic        rmt_send_resp,
    input  logic        aux_cmd_rdy,
    input  logic [7:0]  aux_cmd,
    input  logic [15:0] aux_data,
    output logic        aux_clr_cmd_rdy,
    output logic        aux_send_resp,
    output logic [7:0]  rsp,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    input  logic        motors_off,
    output logic        link_lost
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT_RESP = 2'd2} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_RMT = 2'd1, OWN_AUX = 2'd2, OWN_FS = 2'd3} owner_t;

    state_t              state_q;
    owner_t              owner_q;
    logic                cmd_rdy_q;
    logic [7:0]          cmd_q;
    logic [15:0]         data_q;
    logic [7:0]          rsp_q;
    logic                rmt_send_q;
    logic                aux_send_q;
    logic                fs_pend_q;
    logic                link_lost_q;
    logic [WDOG_W-1:0]   wdog_q;
    logic [WDOG_W-1:0]   wdog_d;

    logic idle, grant_fs, grant_rmt, grant_aux, grant_any, complete, wdog_fire;

    assign idle      = (state_q == S_IDLE);
    assign grant_fs  = idle && fs_pend_q;
    assign grant_rmt = idle && !fs_pend_q && rmt_cmd_rdy;
    assign grant_aux = idle && !fs_pend_q && !rmt_cmd_rdy && aux_cmd_rdy;
    assign grant_any = grant_fs || grant_rmt || grant_aux;

    // Response may coincide with the clear; treat that as an immediate completion.
    assign complete  = ((state_q == S_ISSUE) && clr_cmd_rdy && send_resp) ||
                       ((state_q == S_WAIT_RESP) && send_resp);

    // Fires once per link-loss episode; link_lost stays set until a remote grant.
    assign wdog_fire = (&wdog_q) && !link_lost_q && !motors_off && !grant_rmt;

    always_comb begin
        wdog_d = wdog_q;
        if (motors_off || grant_rmt)
            wdog_d = '0;
        else if (!link_lost_q && !(&wdog_q))
            wdog_d = wdog_q + WDOG_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            cmd_rdy_q   <= 1'b0;
            cmd_q       <= 8'h00;
            data_q      <= 16'h0000;
            rsp_q       <= 8'h00;
            rmt_send_q  <= 1'b0;
            aux_send_q  <= 1'b0;
            fs_pend_q   <= 1'b0;
            link_lost_q <= 1'b0;
            wdog_q      <= '0;
        end else begin
            rmt_send_q <= 1'b0;
            aux_send_q <= 1'b0;
            wdog_q     <= wdog_d;

            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        if (grant_fs) begin
                            cmd_q   <= EMER_OP;
                            data_q  <= 16'h0000;
                            owner_q <= OWN_FS;
                        end else if (grant_rmt) begin
                            cmd_q   <= rmt_cmd;
                            data_q  <= rmt_data;
                            owner_q <= OWN_RMT;
                        end else begin
                            cmd_q   <= aux_cmd;
                            data_q  <= aux_data;
                            owner_q <= OWN_AUX;
                        end
                        cmd_rdy_q <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (clr_cmd_rdy) begin
                        cmd_rdy_q <= 1'b0;
                        state_q   <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: ;
                default: state_q <= S_IDLE;
            endcase

            if (complete) begin
                rsp_q      <= resp;
                rmt_send_q <= (owner_q == OWN_RMT);
                aux_send_q <= (owner_q == OWN_AUX);
                owner_q    <= OWN_NONE;
                state_q    <= S_IDLE;
            end

            if (grant_fs)
                fs_pend_q <= 1'b0;
            else if (wdog_fire)
                fs_pend_q <= 1'b1;

            if (grant_rmt)
                link_lost_q <= 1'b0;
            else if (wdog_fire)
                link_lost_q <= 1'b1;
        end
    end

    // Clears are combinational so a requester sees them in the cycle its rdy is sampled.
    assign rmt_clr_cmd_rdy = grant_rmt && rst_n;
    assign aux_clr_cmd_rdy = grant_aux && rst_n;
    assign rmt_send_resp   = rmt_send_q;
    assign aux_send_resp   = aux_send_q;
    assign rsp             = rsp_q;
    assign cmd_rdy         = cmd_rdy_q;
    assign cmd             = cmd_q;
    assign data            = data_q;
    assign link_lost       = link_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cmd_arbiter : directed self-checking bench for cmd_arbiter.              |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rmt_cmd_rdy = 1'b0;
    logic [7:0]  rmt_cmd = 8'h00;
    logic [15:0] rmt_data = 16'h0000;
    logic        rmt_clr_cmd_rdy, rmt_send_resp;
    logic        aux_cmd_rdy = 1'b0;
    logic [7:0]  aux_cmd = 8'h00;
    logic [15:0] aux_data = 16'h0000;
    logic        aux_clr_cmd_rdy, aux_send_resp;
    logic [7:0]  rsp;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        motors_off = 1'b1;
    logic        link_lost;

    int checks = 0;
    int failures = 0;

    cmd_arbiter #(.WDOG_W(9), .EMER_OP(8'h07)) dut (
        .clk(clk), .rst_n(rst_n),
        .rmt_cmd_rdy(rmt_cmd_rdy), .rmt_cmd(rmt_cmd), .rmt_data(rmt_data),
        .rmt_clr_cmd_rdy(rmt_clr_cmd_rdy), .rmt_send_resp(rmt_send_resp),
        .aux_cmd_rdy(aux_cmd_rdy), .aux_cmd(aux_cmd), .aux_data(aux_data),
        .aux_clr_cmd_rdy(aux_clr_cmd_rdy), .aux_send_resp(aux_send_resp),
        .rsp(rsp), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .motors_off(motors_off), .link_lost(link_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_clr();
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic cfg_resp(input logic [7:0] r);
        send_resp = 1'b1;
        resp      = r;
        step();
        send_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int bad;
        int aux_pulses;

        // Reset state
        repeat (3) step();
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_cmd", cmd, 0);
        check("rst_data", data, 0);
        check("rst_link_lost", link_lost, 0);
        check("rst_pulses", {rmt_clr_cmd_rdy, aux_clr_cmd_rdy, rmt_send_resp, aux_send_resp}, 0);
        rst_n = 1'b1;
        step();

        // Remote SET_PITCH
        rmt_cmd_rdy = 1'b1; rmt_cmd = 8'h02; rmt_data = 16'h0123;
        #1;
        check("t1_rmt_clr_comb", rmt_clr_cmd_rdy, 1);
        step();
        check("t1_cmd_rdy", cmd_rdy, 1);
        check("t1_cmd", cmd, 8'h02);
        check("t1_data", data, 16'h0123);
        check("t1_rmt_clr_single", rmt_clr_cmd_rdy, 0);
        rmt_cmd_rdy = 1'b0;
        repeat (2) step();
        check("t1_cmd_rdy_hold", cmd_rdy, 1);
        cfg_clr();
        check("t1_cmd_rdy_drop", cmd_rdy, 0);
        repeat (2) step();
        check("t1_no_early_resp", rmt_send_resp, 0);
        cfg_resp(8'hA5);
        check("t1_rmt_send", rmt_send_resp, 1);
        check("t1_aux_send", aux_send_resp, 0);
        check("t1_rsp", rsp, 8'hA5);
        step();
        check("t1_rmt_send_single", rmt_send_resp, 0);

        // Simultaneous remote and aux
        rmt_cmd_rdy = 1'b1; rmt_cmd = 8'h03; rmt_data = 16'hBEEF;
        aux_cmd_rdy = 1'b1; aux_cmd = 8'h05; aux_data = 16'h0100;
        #1;
        check("t2_rmt_clr", rmt_clr_cmd_rdy, 1);
        check("t2_aux_clr_held", aux_clr_cmd_rdy, 0);
        step();
        check("t2_cmd_rmt", cmd, 8'h03);
        check("t2_data_rmt", data, 16'hBEEF);
        rmt_cmd_rdy = 1'b0;
        #1;
        check("t2_aux_ignored_issue", aux_clr_cmd_rdy, 0);
        cfg_clr();
        cfg_resp(8'h11);
        check("t2_rmt_send", rmt_send_resp, 1);
        check("t2_aux_send_none", aux_send_resp, 0);
        check("t2_rsp_rmt", rsp, 8'h11);
        check("t2_aux_clr_idle", aux_clr_cmd_rdy, 1);
        step();
        check("t2_cmd_aux", cmd, 8'h05);
        check("t2_data_aux", data, 16'h0100);
        check("t2_cmd_rdy_aux", cmd_rdy, 1);
        aux_cmd_rdy = 1'b0;
        // clear and response in the same cycle
        clr_cmd_rdy = 1'b1;
        cfg_resp(8'h22);
        clr_cmd_rdy = 1'b0;
        check("t2_aux_send", aux_send_resp, 1);
        check("t2_rmt_send_none", rmt_send_resp, 0);
        check("t2_rsp_aux", rsp, 8'h22);
        check("t2_cmd_rdy_low", cmd_rdy, 0);

        // Slow CALIBRATE with a held aux request
        rmt_cmd_rdy = 1'b1; rmt_cmd = 8'h06; rmt_data = 16'h0000;
        step();
        check("t3_cmd_cal", cmd, 8'h06);
        rmt_cmd_rdy = 1'b0;
        cfg_clr();
        aux_cmd_rdy = 1'b1; aux_cmd = 8'h05; aux_data = 16'h0200;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (aux_clr_cmd_rdy || cmd_rdy || rmt_send_resp || aux_send_resp) bad++;
        end
        check("t3_wait_quiet", bad, 0);
        cfg_resp(8'h66);
        check("t3_rmt_send", rmt_send_resp, 1);
        check("t3_aux_send_none", aux_send_resp, 0);
        check("t3_rsp", rsp, 8'h66);
        check("t3_aux_clr", aux_clr_cmd_rdy, 1);
        step();
        check("t3_cmd_aux", cmd, 8'h05);
        check("t3_data_aux", data, 16'h0200);
        aux_cmd_rdy = 1'b0;
        cfg_clr();
        cfg_resp(8'h77);
        check("t3_aux_send", aux_send_resp, 1);
        check("t3_rmt_send_none", rmt_send_resp, 0);

        // Watchdog with no traffic: fires after 2^9 cycles of arming
        do_reset();
        motors_off = 1'b0;
        n = 0;
        while (n < 600) begin
            step();
            n++;
            if (link_lost) break;
        end
        check("wd_fire_cycle", n, 512);
        check("wd_cmd_rdy_before_fs", cmd_rdy, 0);
        step();
        check("wd_fs_cmd_rdy", cmd_rdy, 1);
        check("wd_fs_cmd", cmd, 8'h07);
        check("wd_fs_data", data, 16'h0000);
        cfg_clr();
        cfg_resp(8'h99);
        check("wd_fs_no_send", {rmt_send_resp, aux_send_resp}, 0);
        check("wd_fs_rsp", rsp, 8'h99);
        check("wd_link_lost_held", link_lost, 1);
        rmt_cmd_rdy = 1'b1; rmt_cmd = 8'h01; rmt_data = 16'h0011;
        step();
        check("wd_rmt_clears_ll", link_lost, 0);
        check("wd_rmt_cmd", cmd, 8'h01);
        rmt_cmd_rdy = 1'b0;
        motors_off = 1'b1;
        cfg_clr();
        cfg_resp(8'h01);
        check("wd_rmt_send", rmt_send_resp, 1);

        // Watchdog under periodic aux traffic
        do_reset();
        motors_off = 1'b0;
        aux_cmd = 8'h05; aux_data = 16'h0100;
        n = 0;
        aux_pulses = 0;
        while (n < 600) begin
            step();
            n++;
            if (aux_send_resp) aux_pulses++;
            if (link_lost) break;
            case (n % 50)
                1: aux_cmd_rdy = 1'b1;
                2: aux_cmd_rdy = 1'b0;
                4: clr_cmd_rdy = 1'b1;
                5: clr_cmd_rdy = 1'b0;
                7: begin send_resp = 1'b1; resp = 8'h55; end
                8: send_resp = 1'b0;
                default: ;
            endcase
        end
        check("wd_aux_fire_cycle", n, 512);
        check("wd_aux_pulses", aux_pulses, 11);

        // Failsafe wins over a simultaneous remote request
        rmt_cmd_rdy = 1'b1; rmt_cmd = 8'h04; rmt_data = 16'h4444;
        #1;
        check("fs_prio_rmt_clr", rmt_clr_cmd_rdy, 0);
        step();
        check("fs_prio_cmd", cmd, 8'h07);
        check("fs_prio_ll", link_lost, 1);

        // Reset during ISSUE
        rst_n = 1'b0;
        #1;
        check("arst_cmd_rdy", cmd_rdy, 0);
        check("arst_link_lost", link_lost, 0);
        check("arst_pulses", {rmt_clr_cmd_rdy, aux_clr_cmd_rdy, rmt_send_resp, aux_send_resp}, 0);
        motors_off = 1'b1;
        #2;
        rst_n = 1'b1;
        #1;
        check("arst_regrant_clr", rmt_clr_cmd_rdy, 1);
        step();
        check("arst_regrant_cmd", cmd, 8'h04);
        check("arst_regrant_data", data, 16'h4444);
        rmt_cmd_rdy = 1'b0;
        cfg_clr();
        cfg_resp(8'h44);
        check("arst_rmt_send", rmt_send_resp, 1);

        // motors_off holds the watchdog at zero
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (link_lost || cmd_rdy) bad++;
        end
        check("wd_disarmed", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
